// File: rtl/load_store_unit.sv
// Load/store stage in front of a word-wide data memory: splits misaligned
// accesses into two word cycles and merges partial stores via read-modify-write.
module load_store_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iValid,
    input  logic        iWe,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWriteData,
    output logic        oReady,
    output logic        oDone,
    output logic        oFault,
    output logic [31:0] oLoadData,
    output logic        oMemWriteEn,
    output logic [31:0] oWordAddr,
    output logic [7:0]  oByte1,
    output logic [7:0]  oByte2,
    output logic [7:0]  oByte3,
    output logic [7:0]  oByte4,
    input  logic [31:0] iMemData
);

    typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_WR0, S_WR1, S_DONE} state_t;

    state_t      state_reg, state_next;
    logic        we_reg, cross_reg, fault_reg;
    logic [2:0]  funct3_reg, size_reg;
    logic [1:0]  off_reg;
    logic [31:0] word0_reg, word1_reg, wdata_reg;
    logic [31:0] buf0_reg, buf1_reg, load_data_reg;

    logic        accept;
    logic [2:0]  req_size, req_end, store_end;
    logic        req_illegal, req_cross, req_fault, req_aligned_sw;
    logic [7:0]  load_win [8];
    logic [7:0]  merged [8];
    logic [7:0]  ld_byte [4];
    logic [31:0] load_ext;

    assign accept = iValid && (state_reg == S_IDLE);

    always_comb begin
        case (iFunct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
    end

    assign req_end        = {1'b0, iAddr[1:0]} + req_size;
    assign req_cross      = req_end > 3'd4;
    assign req_illegal    = (iFunct3 == 3'b011) || (iFunct3[2:1] == 2'b11) || (iWe && iFunct3[2]);
    assign req_fault      = req_illegal || (req_cross && !ALLOW_MISALIGNED);
    assign req_aligned_sw = iWe && (iFunct3 == 3'b010) && (iAddr[1:0] == 2'b00);
    assign store_end      = {1'b0, off_reg} + size_reg;

    // Byte window spanning word0 (bytes 0..3) and word1 (bytes 4..7). The load
    // view substitutes the word arriving this cycle so the result can be registered
    // on the same edge that ends the last read.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_win
            localparam logic [2:0] IDX = 3'(gi);
            logic [1:0] rel;
            logic       in_store;
            assign rel      = IDX[1:0] - off_reg;
            assign in_store = (IDX >= {1'b0, off_reg}) && (IDX < store_end);
            if (gi < 4) begin : g_lo
                assign load_win[gi] = (state_reg == S_RD0) ? iMemData[8*gi +: 8] : buf0_reg[8*gi +: 8];
                assign merged[gi]   = in_store ? wdata_reg[{rel, 3'b000} +: 8] : buf0_reg[8*gi +: 8];
            end else begin : g_hi
                assign load_win[gi] = (state_reg == S_RD1) ? iMemData[8*(gi-4) +: 8] : buf1_reg[8*(gi-4) +: 8];
                assign merged[gi]   = in_store ? wdata_reg[{rel, 3'b000} +: 8] : buf1_reg[8*(gi-4) +: 8];
            end
        end
        for (gi = 0; gi < 4; gi++) begin : g_ld
            assign ld_byte[gi] = load_win[3'(gi) + {1'b0, off_reg}];
        end
    endgenerate

    always_comb begin
        case (funct3_reg)
            3'b000:  load_ext = {{24{ld_byte[0][7]}}, ld_byte[0]};
            3'b100:  load_ext = {24'h0, ld_byte[0]};
            3'b001:  load_ext = {{16{ld_byte[1][7]}}, ld_byte[1], ld_byte[0]};
            3'b101:  load_ext = {16'h0, ld_byte[1], ld_byte[0]};
            default: load_ext = {ld_byte[3], ld_byte[2], ld_byte[1], ld_byte[0]};
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_reg     <= S_IDLE;
            we_reg        <= 1'b0;
            cross_reg     <= 1'b0;
            fault_reg     <= 1'b0;
            funct3_reg    <= 3'b0;
            size_reg      <= 3'b0;
            off_reg       <= 2'b0;
            word0_reg     <= 32'h0;
            word1_reg     <= 32'h0;
            wdata_reg     <= 32'h0;
            buf0_reg      <= 32'h0;
            buf1_reg      <= 32'h0;
            load_data_reg <= 32'h0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg     <= iWe;
                cross_reg  <= req_cross;
                fault_reg  <= req_fault;
                funct3_reg <= iFunct3;
                size_reg   <= req_size;
                off_reg    <= iAddr[1:0];
                word0_reg  <= {iAddr[31:2], 2'b00};
                word1_reg  <= {iAddr[31:2], 2'b00} + 32'd4;
                wdata_reg  <= iWriteData;
            end
            if (state_reg == S_RD0) buf0_reg <= iMemData;
            if (state_reg == S_RD1) buf1_reg <= iMemData;
            if (!we_reg && (((state_reg == S_RD0) && !cross_reg) || (state_reg == S_RD1)))
                load_data_reg <= load_ext;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) begin
                if (req_fault)           state_next = S_DONE;
                else if (req_aligned_sw) state_next = S_WR0;
                else                     state_next = S_RD0;
            end
            S_RD0:   state_next = cross_reg ? S_RD1 : (we_reg ? S_WR0 : S_DONE);
            S_RD1:   state_next = we_reg ? S_WR0 : S_DONE;
            S_WR0:   state_next = cross_reg ? S_WR1 : S_DONE;
            S_WR1:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        oReady      = (state_reg == S_IDLE);
        oDone       = (state_reg == S_DONE);
        oFault      = (state_reg == S_DONE) && fault_reg;
        oLoadData   = load_data_reg;
        oMemWriteEn = 1'b0;
        oWordAddr   = 32'h0;
        oByte1      = 8'h0;
        oByte2      = 8'h0;
        oByte3      = 8'h0;
        oByte4      = 8'h0;
        case (state_reg)
            S_RD0: oWordAddr = word0_reg;
            S_RD1: oWordAddr = word1_reg;
            S_WR0: begin
                oMemWriteEn = 1'b1;
                oWordAddr   = word0_reg;
                {oByte4, oByte3, oByte2, oByte1} = {merged[3], merged[2], merged[1], merged[0]};
            end
            S_WR1: begin
                oMemWriteEn = 1'b1;
                oWordAddr   = word1_reg;
                {oByte4, oByte3, oByte2, oByte1} = {merged[7], merged[6], merged[5], merged[4]};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model driving the DUT, byte-level
// reference memory predicting loads, stores, faults and cycle counts.
module tb_load_store_unit;

    logic        iClk = 1'b0;
    logic        iRstN = 1'b0;
    logic        iValid = 1'b0;
    logic        iWe = 1'b0;
    logic [2:0]  iFunct3 = 3'b0;
    logic [31:0] iAddr = 32'h0;
    logic [31:0] iWriteData = 32'h0;
    logic [31:0] iMemData = 32'h0;
    logic        oReady, oDone, oFault, oMemWriteEn;
    logic [31:0] oLoadData, oWordAddr;
    logic [7:0]  oByte1, oByte2, oByte3, oByte4;

    logic        nm_valid = 1'b0;
    logic [31:0] nm_mem_data = 32'h0;
    logic        nm_ready, nm_done, nm_fault, nm_we;
    logic [31:0] nm_load_data, nm_word_addr;
    logic [7:0]  nm_b1, nm_b2, nm_b3, nm_b4;
    bit          nm_wr_seen = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_words [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] last_load = 32'h0;
    logic [31:0] rd_addrs [$];
    logic [31:0] wr_data [$];

    always #5 iClk = ~iClk;

    load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .iWe(iWe), .iFunct3(iFunct3),
        .iAddr(iAddr), .iWriteData(iWriteData), .oReady(oReady), .oDone(oDone),
        .oFault(oFault), .oLoadData(oLoadData), .oMemWriteEn(oMemWriteEn),
        .oWordAddr(oWordAddr), .oByte1(oByte1), .oByte2(oByte2), .oByte3(oByte3),
        .oByte4(oByte4), .iMemData(iMemData)
    );

    load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_nm (
        .iClk(iClk), .iRstN(iRstN), .iValid(nm_valid), .iWe(iWe), .iFunct3(iFunct3),
        .iAddr(iAddr), .iWriteData(iWriteData), .oReady(nm_ready), .oDone(nm_done),
        .oFault(nm_fault), .oLoadData(nm_load_data), .oMemWriteEn(nm_we),
        .oWordAddr(nm_word_addr), .oByte1(nm_b1), .oByte2(nm_b2), .oByte3(nm_b3),
        .oByte4(nm_b4), .iMemData(nm_mem_data)
    );

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem_words.exists(a) ? mem_words[a] : 32'h0;
    endfunction

    // Memory answers on the falling edge, writes land on the rising edge.
    always @(negedge iClk) iMemData = rd_word(oWordAddr);
    always @(posedge iClk) begin
        if (oMemWriteEn) mem_words[oWordAddr] = {oByte4, oByte3, oByte2, oByte1};
        if (nm_we) nm_wr_seen = 1'b1;
    end

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_byte(a + 3), ref_byte(a + 2), ref_byte(a + 1), ref_byte(a)};
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit crosses(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) + size_of(f3)) > 4;
    endfunction

    function automatic bit is_fault(input logic we, input logic [2:0] f3, input logic [31:0] a, input bit allow);
        bit illegal;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
        return illegal || (crosses(f3, a) && !allow);
    endfunction

    function automatic int exp_cycles(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (is_fault(we, f3, a, 1'b1)) return 1;
        if (we) begin
            if (f3 == 3'b010 && a[1:0] == 2'b00) return 2;
            return crosses(f3, a) ? 5 : 3;
        end
        return crosses(f3, a) ? 3 : 2;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v = 32'h0;
        int n = size_of(f3);
        for (int j = 0; j < n; j++) v[8*j +: 8] = ref_byte(a + 32'(j));
        if (f3 == 3'b000 && v[7])  v[31:8]  = 24'hFFFFFF;
        if (f3 == 3'b001 && v[15]) v[31:16] = 16'hFFFF;
        return v;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        mem_words[a] = w;
        for (int j = 0; j < 4; j++) ref_mem[a + 32'(j)] = w[8*j +: 8];
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int cyc, output bit wr_seen);
        int g = 0;
        while (!oReady && g < 20) begin @(posedge iClk); #1; g++; end
        iWe = we; iFunct3 = f3; iAddr = a; iWriteData = wd; iValid = 1'b1;
        @(posedge iClk); #1;
        iValid = 1'b0;
        cyc = 1; wr_seen = 1'b0;
        rd_addrs.delete(); wr_data.delete();
        while (!oDone && cyc < 20) begin
            if (oMemWriteEn) begin
                wr_seen = 1'b1;
                wr_data.push_back({oByte4, oByte3, oByte2, oByte1});
            end else begin
                rd_addrs.push_back(oWordAddr);
            end
            @(posedge iClk); #1;
            cyc++;
        end
    endtask

    // Issues one request and checks it fully against the reference model.
    task automatic check_req(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        int cyc;
        bit wr_seen;
        bit f = is_fault(we, f3, a, 1'b1);
        logic [31:0] w0 = {a[31:2], 2'b00};
        do_req(we, f3, a, wd, cyc, wr_seen);
        $display("req %s we=%0b f3=%03b addr=%h wd=%h cycles=%0d fault=%0b ld=%h",
                 tag, we, f3, a, wd, cyc, oFault, oLoadData);
        check32({tag, ".done"}, 32'(oDone), 32'd1);
        check32({tag, ".cycles"}, 32'(cyc), 32'(exp_cycles(we, f3, a)));
        check32({tag, ".fault"}, 32'(oFault), 32'(f));
        if (!we && !f) last_load = exp_load(f3, a);
        check32({tag, ".load"}, oLoadData, last_load);
        if (f || !we) begin
            check32({tag, ".nowrite"}, 32'(wr_seen), 32'd0);
        end else begin
            for (int j = 0; j < size_of(f3); j++) ref_mem[a + 32'(j)] = wd[8*j +: 8];
            check32({tag, ".mem0"}, rd_word(w0), ref_word(w0));
            if (crosses(f3, a)) check32({tag, ".mem1"}, rd_word(w0 + 32'd4), ref_word(w0 + 32'd4));
        end
    endtask

    task automatic std_preload();
        preload(32'h10000, 32'h11223344);
        preload(32'h10004, 32'h55667788);
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rf;
        int          g;

        #1;
        check32("rst.ready", 32'(oReady), 32'd1);
        check32("rst.done", 32'(oDone), 32'd0);
        check32("rst.fault", 32'(oFault), 32'd0);
        check32("rst.load", oLoadData, 32'h0);
        check32("rst.we", 32'(oMemWriteEn), 32'd0);
        check32("rst.addr", oWordAddr, 32'h0);
        check32("rst.lanes", {oByte4, oByte3, oByte2, oByte1}, 32'h0);
        repeat (2) @(negedge iClk);
        iRstN = 1'b1;
        @(posedge iClk); #1;

        std_preload();
        check_req("sw", 1'b1, 3'b010, 32'h10000, 32'hDEADBEEF);
        check32("sw.reads", 32'(rd_addrs.size()), 32'd0);
        check32("sw.lanes", wr_data[0], 32'hDEADBEEF);
        check_req("sw.lw", 1'b0, 3'b010, 32'h10000, 32'h0);
        check32("sw.readback", oLoadData, 32'hDEADBEEF);

        std_preload();
        check_req("sb", 1'b1, 3'b000, 32'h10001, 32'h000000AB);
        check32("sb.word", mem_words[32'h10000], 32'h1122AB44);

        std_preload();
        check_req("lw.x", 1'b0, 3'b010, 32'h10002, 32'h0);
        check32("lw.x.val", oLoadData, 32'h77881122);
        check32("lw.x.rd1", rd_addrs[1], 32'h10004);
        check_req("lhu.x", 1'b0, 3'b101, 32'h10003, 32'h0);
        check32("lhu.x.val", oLoadData, 32'h00008811);
        check_req("lh.x", 1'b0, 3'b001, 32'h10003, 32'h0);
        check32("lh.x.val", oLoadData, 32'hFFFF8811);

        check_req("sh.x", 1'b1, 3'b001, 32'h10003, 32'h0000CAFE);
        check32("sh.x.wr0", wr_data[0], 32'hFE223344);
        check32("sh.x.wr1", wr_data[1], 32'h556677CA);

        check_req("bad.f3", 1'b0, 3'b011, 32'h10000, 32'h0);
        check_req("bad.sbu", 1'b1, 3'b100, 32'h10000, 32'h12345678);

        // Same misaligned SH on the instance that forbids crossing accesses.
        iWe = 1'b1; iFunct3 = 3'b001; iAddr = 32'h10003; iWriteData = 32'h0000CAFE;
        nm_valid = 1'b1;
        @(posedge iClk); #1;
        nm_valid = 1'b0;
        $display("req nm.sh we=1 f3=001 addr=00010003 done=%0b fault=%0b ld=%h", nm_done, nm_fault, nm_load_data);
        check32("nm.done", 32'(nm_done), 32'd1);
        check32("nm.fault", 32'(nm_fault), 32'd1);
        check32("nm.load", nm_load_data, 32'h0);
        @(posedge iClk); #1;
        check32("nm.ready", 32'(nm_ready), 32'd1);
        check32("nm.nowrite", 32'(nm_wr_seen), 32'd0);

        preload(32'hFFFFFFFC, 32'hA1B2C3D4);
        preload(32'h00000000, 32'h0F1E2D3C);
        check_req("wrap.lw", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
        check32("wrap.rd1", rd_addrs[1], 32'h0);
        check32("wrap.val", oLoadData, 32'h2D3CA1B2);

        for (int a = 32'h10000; a <= 32'h10020; a += 4) preload(32'(a), $urandom);
        for (int i = 0; i < 48; i++) begin
            ra = 32'h10000 + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            rf = 3'($urandom_range(0, 7));
            check_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), rf, ra, $urandom);
        end

        // Reset during WR1 of a crossing store: word0 keeps the new byte, word1 untouched.
        std_preload();
        g = 0;
        while (!oReady && g < 20) begin @(posedge iClk); #1; g++; end
        iWe = 1'b1; iFunct3 = 3'b001; iAddr = 32'h10003; iWriteData = 32'h00001234; iValid = 1'b1;
        @(posedge iClk); #1;
        iValid = 1'b0;
        g = 0;
        while (!(oMemWriteEn && oWordAddr == 32'h10004) && g < 20) begin @(posedge iClk); #1; g++; end
        check32("rst.mid.wr1", 32'(oMemWriteEn), 32'd1);
        iRstN = 1'b0;
        #1;
        $display("req rst.mid we=%0b ready=%0b ld=%h", oMemWriteEn, oReady, oLoadData);
        check32("rst.mid.we", 32'(oMemWriteEn), 32'd0);
        check32("rst.mid.ready", 32'(oReady), 32'd1);
        check32("rst.mid.load", oLoadData, 32'h0);
        @(negedge iClk);
        @(negedge iClk);
        iRstN = 1'b1;
        ref_mem[32'h10003] = 8'h34;
        last_load = 32'h0;
        check32("rst.mid.word0", rd_word(32'h10000), 32'h34223344);
        check32("rst.mid.word1", rd_word(32'h10004), 32'h55667788);
        @(posedge iClk); #1;
        check_req("post.rst.lw", 1'b0, 3'b010, 32'h10002, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage placed directly upstream of the data memory. Accepts one load/store request at a time from the pipeline: byte address, RISC-V funct3 and store data. Drives the memory's word-aligned address, write enable and four byte lanes. Partial and misaligned stores become read-modify-write sequences, and misaligned loads become two-word reads. Load results come back zero- or sign-extended.

## Interface
- ALLOW_MISALIGNED, 1, 1: accesses crossing a word boundary are split into two word accesses; 0: they fault with no memory access.
- iClk  in  1  clock; all state changes on rising edge.
- iRstN  in  1  asynchronous, active-low reset.
- iValid  in  1  request present; accepted when iValid && oReady at a rising edge.
- iWe  in  1  1 = store, 0 = load.
- iFunct3  in  3  000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- iAddr  in  32  byte address.
- iWriteData  in  32  store data; low bytes used for B/H.
- oReady  out  1  high only in IDLE.
- oDone  out  1  one-cycle pulse at request completion.
- oFault  out  1  valid with oDone; illegal funct3 or disallowed misalignment.
- oLoadData  out  32  extended load result; valid with oDone, held until next oDone.
- oMemWriteEn  out  1  memory write enable.
- oWordAddr  out  32  byte address with bits [1:0] = 0.
- oByte1..oByte4  out  8 each  lanes for word offsets +0..+3 (oByte1 = bits 7:0).
- iMemData  in  32  memory read word; [7:0] = offset +0.

## Operation
- Request fields are latched on acceptance. Inputs are don't-care afterwards.
- Little-endian. Access size is 1, 2 or 4 bytes. Word0 = iAddr & ~3. An access crosses when (iAddr[1:0] + size) > 4. Word1 = word0 + 4, computed mod 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- Fault cases: funct3 ∈ {011,110,111}; a store with funct3 100/101; a crossing access with ALLOW_MISALIGNED=0. A fault goes to DONE with oFault=1, makes no memory access, and leaves oLoadData unchanged.
- States: IDLE, RD0, RD1, WR0, WR1, DONE.
- Transitions from IDLE on accept:
  - fault → DONE
  - aligned SW → WR0
  - any other store or any load → RD0
- RD0 → RD1 if crossing; otherwise WR0 for a store or DONE for a load.
- RD1 → WR0 for a store, DONE for a load.
- WR0 → WR1 if crossing, else DONE. WR1 → DONE. DONE → IDLE.
- RD states: oMemWriteEn=0. oWordAddr = word0 (RD0) or word1 (RD1). iMemData is captured into the merge buffer at the rising edge ending the RD cycle, because memory responds on the falling edge within that cycle.
- WR states: oMemWriteEn=1, oWordAddr = word0/word1. Lanes are the read word with the targeted bytes replaced by store bytes in ascending address order. Aligned SW drives iWriteData bytes directly.
- Loads: bytes are assembled from the captured word(s) starting at iAddr[1:0]. B/H are sign-extended; BU/HU are zero-extended.

## Timing
- Accept at edge k. oDone is high in the cycle after the last memory cycle. Cycles from acceptance to oDone:
  - fault: 1
  - aligned SW: 2
  - non-crossing load: 2
  - crossing load: 3
  - non-crossing SB/SH: 3
  - crossing store: 5
- Next accept is possible the cycle after oDone (state returns to IDLE).
- iValid while oReady=0 is ignored. The pipeline must hold the request.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- Reset values: state IDLE, oReady=1, oDone=0, oFault=0, oLoadData=0, oMemWriteEn=0, oWordAddr=0, oByte1..4=0.
- Reset mid-operation drops oMemWriteEn asynchronously and abandons the request. A crossing store interrupted after WR0 leaves word0 written and word1 untouched.

## Test plan
- Preload 0x10000=0x11223344, 0x10004=0x55667788.
- SW 0xDEADBEEF at 0x10000 → one WR cycle, no RD, lanes EF,BE,AD,DE, oDone 2 cycles after accept, memory reads back 0xDEADBEEF.
- SB 0xAB at 0x10001 → RD0, WR0 with word 0x1122AB44, oDone at cycle 3, other bytes preserved.
- LW at 0x10002 → RD0 0x10000, RD1 0x10004, oLoadData=0x77881122 at cycle 3; LHU at 0x10003 → 0x00008811; LH → 0xFFFF8811.
- SH 0xCAFE at 0x10003 → RD0, RD1, WR0 0xFE223344, WR1 0x556677CA, oDone at cycle 5.
- iFunct3=011, or SH at 0x10003 with ALLOW_MISALIGNED=0 → oDone+oFault at cycle 1, oMemWriteEn never high, oLoadData unchanged.
- Assert iRstN low during WR1 of a crossing store → oMemWriteEn=0 immediately, oReady=1, word1 unchanged.
- Wrap case: LW at 0xFFFFFFFE → second read at 0x00000000.
